// File: rtl/uart_mem_loader.sv
// UART firmware loader: receives a framed, XOR-checksummed image and writes it to bram as
// 32-bit words. The CPU is held in reset until a verified image has been stored.
module uart_mem_loader #(
    parameter int unsigned CLK_FREQ    = 25_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned MAX_WORDS   = 2048,
    parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rxd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_resetn
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync;
    logic [31:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        byte_stb, frame_err;
    logic [7:0]  rx_byte;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= RX_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            rx_byte   <= '0;
        end else begin
            rx_meta   <= uart_rxd;
            rx_sync   <= rx_meta;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    // A start bit that is gone by mid-bit is treated as a line glitch.
                    if (bit_cnt == HALF_BIT - 1) begin
                        bit_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == CLKS_PER_BIT - 1) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == CLKS_PER_BIT - 1) begin
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_stb <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 32'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    state_t      state;
    logic [15:0] count, word_idx;
    logic [1:0]  lane;
    logic [7:0]  csum;
    logic [23:0] wbuf;
    logic [31:0] tmo_cnt;
    logic        in_frame, tmo_hit;
    logic [15:0] len_word;

    assign in_frame = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
    assign tmo_hit  = (tmo_cnt == TIMEOUT_CYC - 1);
    assign len_word = {rx_byte, count[7:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_resetn <= 1'b0;
            count      <= '0;
            word_idx   <= '0;
            lane       <= '0;
            csum       <= '0;
            wbuf       <= '0;
            tmo_cnt    <= '0;
        end else begin
            mem_wmask <= '0;
            if (in_frame && !byte_stb) tmo_cnt <= tmo_cnt + 32'd1;
            else                       tmo_cnt <= '0;

            if (frame_err && state != S_IDLE) begin
                state <= S_ERROR; busy <= 1'b0; done <= 1'b0; err <= 1'b1; cpu_resetn <= 1'b0;
            end else if (byte_stb) begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state      <= S_LEN0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            cpu_resetn <= 1'b0;
                            csum       <= '0;
                        end
                    end
                    S_LEN0: begin
                        count[7:0] <= rx_byte;
                        state      <= S_LEN1;
                    end
                    S_LEN1: begin
                        count[15:8] <= rx_byte;
                        if (len_word == 16'd0 || 32'(len_word) > MAX_WORDS) begin
                            state <= S_ERROR; busy <= 1'b0; done <= 1'b0; err <= 1'b1; cpu_resetn <= 1'b0;
                        end else begin
                            state    <= S_DATA;
                            word_idx <= '0;
                            lane     <= '0;
                        end
                    end
                    S_DATA: begin
                        csum <= csum ^ rx_byte;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: wbuf[7:0]   <= rx_byte;
                            2'd1: wbuf[15:8]  <= rx_byte;
                            2'd2: wbuf[23:16] <= rx_byte;
                            default: begin
                                mem_wdata <= {rx_byte, wbuf};
                                mem_addr  <= BASE_ADDR + {14'b0, word_idx, 2'b00};
                                mem_wmask <= '1;
                                word_idx  <= word_idx + 16'd1;
                                if (word_idx + 16'd1 == count) state <= S_CSUM;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (rx_byte == csum) begin
                            state <= S_DONE; busy <= 1'b0; done <= 1'b1; err <= 1'b0; cpu_resetn <= 1'b1;
                        end else begin
                            state <= S_ERROR; busy <= 1'b0; done <= 1'b0; err <= 1'b1; cpu_resetn <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (in_frame && tmo_hit) begin
                state <= S_ERROR; busy <= 1'b0; done <= 1'b0; err <= 1'b1; cpu_resetn <= 1'b0;
            end
        end
    end
endmodule
